pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter CTRL_W, default 24, SHALL set the width of the control field that is zeroed on flush and reset.
REQ-002 Parameter DATA_W, default 128, SHALL set the width of the payload field (operands, immediate, PC).
REQ-003 Parameter SKID, default 1, SHALL select a 2-entry skid buffer (1) or a single entry (0).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  invalidate all held entries (branch/jump squash).
REQ-007 stall  input  1  downstream hold; acts as out_ready forced low.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts the head entry.
REQ-014 out_ctrl  output  CTRL_W  head control, zero whenever out_valid=0.
REQ-015 out_data  output  DATA_W  head payload.
REQ-016 occupancy  output  2  number of held entries, 0..2.

Function
REQ-017 Accept SHALL occur when in_valid=1 and in_ready=1; release SHALL occur when out_valid=1, out_ready=1 and stall=0.
REQ-018 The FSM SHALL have states EMPTY, ONE and TWO; TWO SHALL be reachable only when SKID=1.
REQ-019 Transitions: EMPTY+accept->ONE; ONE+accept only->TWO (SKID=1); ONE+release only->EMPTY; ONE+accept+release->ONE; TWO+release->ONE; all other cases hold.
REQ-020 in_ready SHALL be a registered output: 1 in EMPTY; 1 in ONE when SKID=1; 0 in TWO; in ONE with SKID=0 it SHALL equal the registered value of "next state is EMPTY or a release is expected" and SHALL otherwise be 0, so that SKID=0 stalls upstream for one cycle per entry unless released.
REQ-021 Latency SHALL be exactly one cycle: an entry accepted at edge N SHALL be visible on out_* after edge N when the stage was EMPTY.
REQ-022 Ordering SHALL be FIFO; the skid entry SHALL move to the head on the edge that releases the head.
REQ-023 An accept in TWO SHALL be impossible; an in_valid while in_ready=0 SHALL leave all state unchanged and drop nothing, because upstream holds.
REQ-024 A flush SHALL, on the next edge, force the state to EMPTY, out_valid=0, out_ctrl=0 and occupancy=0, and in_ready=1.
REQ-025 A flush coinciding with an accept SHALL discard the incoming entry; a flush coinciding with a release SHALL still count the release as taken downstream.
REQ-026 out_data SHALL retain its last value when empty or flushed; only ctrl is guaranteed zero.
REQ-027 Stall SHALL NOT block accepts while space exists (ONE->TWO under stall with SKID=1).

Reset
REQ-028 On reset the block SHALL load state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0 and in_ready=1 on the next edge.
REQ-029 Reset SHALL take priority over flush, stall and all handshakes, including mid-skid (TWO).
REQ-030 The first accept SHALL be possible on the first edge after reset deasserts.

Structure
REQ-031 The FSM state encoding and the default widths (CTRL_W, DATA_W) SHALL be placed in the shared package pipe_pkg.
REQ-032 One sub-module, pipe_entry_reg (a ctrl+data register with load and clear), SHALL be instantiated for the head entry and, when SKID=1, for the skid entry.

Verification
REQ-033 Reset during TWO with ctrl=0xABCDEF -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-034 Stream 8 entries, data=1..8, out_ready=1, stall=0 -> outputs 1..8 in order, one per cycle, one-cycle latency, in_ready constantly 1.
REQ-035 SKID=1; accept A=0x11 then B=0x22 under stall=1 -> occupancy=2, in_ready=0; release stall -> A then B on consecutive cycles.
REQ-036 flush asserted with in_valid=1, data=0x33, while holding 0x22 -> next cycle out_valid=0, out_ctrl=0; 0x33 never appears.
REQ-037 SKID=0; back-to-back in_valid with out_ready=0 -> in_ready=0 after the first accept; no entry is lost or duplicated.
REQ-038 Random valid/ready/stall/flush for 10k cycles, with a scoreboard -> output sequence equals the unflushed input sequence, and occupancy always equals the scoreboard depth.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM state encoding and default field widths for the pipeline skid stage.
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    localparam int CTRL_W_DEF = 24;
    localparam int DATA_W_DEF = 128;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one held pipeline entry; clear zeroes only ctrl so data keeps its last value.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_clear) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage with registered in_ready and optional 2-entry skid buffer,
// flushable for branch squash.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    state_t            r_state, w_next;
    logic              r_in_ready;
    logic              w_accept, w_release, w_out_valid, w_head_load;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_out_valid = r_state != EMPTY;
    assign w_accept    = in_valid && r_in_ready;
    assign w_release   = w_out_valid && out_ready && !stall;

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_next = ONE;
            ONE: begin
                if (w_accept && !w_release && SKID != 0) w_next = TWO;
                else if (!w_accept && w_release) w_next = EMPTY;
            end
            TWO: if (w_release) w_next = ONE;
            default: w_next = EMPTY;
        endcase
        if (flush) w_next = EMPTY;
    end

    // Without a skid slot, ready only reopens once the head has drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (SKID != 0) ? (w_next != TWO) : (w_next == EMPTY);
        end
    end

    assign w_head_load = (w_accept && (r_state == EMPTY || w_release)) || (r_state == TWO && w_release);

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_next == EMPTY),
        .i_load  (w_head_load),
        .i_ctrl  ((r_state == TWO) ? w_skid_ctrl : in_ctrl),
        .i_data  ((r_state == TWO) ? w_skid_data : in_data),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clock   (clock),
            .reset   (reset),
            .i_clear (flush),
            .i_load  (w_accept && r_state == ONE && !w_release),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data)
        );
    end else begin : g_noskid
        assign w_skid_ctrl = '0;
        assign w_skid_data = '0;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign occupancy = r_state;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and scoreboarded checks of a SKID=1 and a SKID=0 stage.
`timescale 1ns/1ps
module tb_pipe_skid_stage;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush, stall, in_valid, in_ready, out_valid, out_ready;
    logic [23:0]  in_ctrl, out_ctrl;
    logic [127:0] in_data, out_data;
    logic [1:0]   occupancy;
    logic         z_flush, z_stall, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [23:0]  z_in_ctrl, z_out_ctrl;
    logic [127:0] z_in_data, z_out_data;
    logic [1:0]   z_occupancy;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {logic [23:0] c; logic [127:0] d;} ent_t;
    ent_t q[$];

    always #5 clock = ~clock;

    pipe_skid_stage #(.CTRL_W(24), .DATA_W(128), .SKID(1)) dut (
        .clock(clock), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_stage #(.CTRL_W(24), .DATA_W(128), .SKID(0)) dut0 (
        .clock(clock), .reset(reset), .flush(z_flush), .stall(z_stall),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occupancy)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
        z_flush = 0; z_stall = 0; z_in_valid = 0; z_out_ready = 0; z_in_ctrl = '0; z_in_data = '0;
    endtask

    task automatic test_reset;
        reset = 1; idle(); tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL rst_ctrl got=%0h exp=0", out_ctrl); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL rst_data got=%0h exp=0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
        n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready0 got=%0h exp=1", z_in_ready); end
        reset = 0;
    endtask

    task automatic test_reset_mid_skid;
        stall = 1; out_ready = 1; in_valid = 1; in_ctrl = 24'hABCDEF; in_data = 128'h5A5A;
        tick();
        in_data = 128'h5A5B;
        tick();
        in_valid = 0;
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL mid_occ2 got=%0d exp=2", occupancy); end
        reset = 1; tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL mid_ctrl got=%0h exp=0", out_ctrl); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL mid_data got=%0h exp=0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%0h exp=1", in_ready); end
        reset = 0; idle();
    endtask

    task automatic test_stream;
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_ctrl = 24'h100 | 24'(i); in_data = 128'(i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL str_ready[%0d] got=%0h exp=1", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL str_valid[%0d] got=%0h exp=1", i, out_valid); end
            n_cmp++; if (out_data !== 128'(i)) begin n_err++; $display("FAIL str_data[%0d] got=%0h exp=%0h", i, out_data, i); end
            n_cmp++; if (out_ctrl !== (24'h100 | 24'(i))) begin n_err++; $display("FAIL str_ctrl[%0d] got=%0h exp=%0h", i, out_ctrl, 24'h100 | 24'(i)); end
        end
        in_valid = 0; tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL str_end_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL str_end_ctrl got=%0h exp=0", out_ctrl); end
        n_cmp++; if (out_data !== 128'h8) begin n_err++; $display("FAIL str_end_data got=%0h exp=8", out_data); end
        idle();
    endtask

    task automatic test_skid;
        stall = 1; out_ready = 1; in_valid = 1; in_ctrl = 24'h11; in_data = 128'h11;
        tick();
        in_ctrl = 24'h22; in_data = 128'h22;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready1 got=%0h exp=1", in_ready); end
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL skid_occ2 got=%0d exp=2", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready2 got=%0h exp=0", in_ready); end
        n_cmp++; if (out_data !== 128'h11) begin n_err++; $display("FAIL skid_headA got=%0h exp=11", out_data); end
        in_ctrl = 24'h99; in_data = 128'h99;
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL skid_hold_occ got=%0d exp=2", occupancy); end
        n_cmp++; if (out_data !== 128'h11) begin n_err++; $display("FAIL skid_hold_head got=%0h exp=11", out_data); end
        in_valid = 0; stall = 0;
        tick();
        n_cmp++; if (out_data !== 128'h22) begin n_err++; $display("FAIL skid_headB got=%0h exp=22", out_data); end
        n_cmp++; if (out_ctrl !== 24'h22) begin n_err++; $display("FAIL skid_ctrlB got=%0h exp=22", out_ctrl); end
        n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL skid_occ1 got=%0d exp=1", occupancy); end
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL skid_occ0 got=%0d exp=0", occupancy); end
        idle();
    endtask

    task automatic test_flush;
        stall = 1; in_valid = 1; in_ctrl = 24'h22; in_data = 128'h22;
        tick();
        flush = 1; in_ctrl = 24'h33; in_data = 128'h33;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL fl_ctrl got=%0h exp=0", out_ctrl); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL fl_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready got=%0h exp=1", in_ready); end
        idle(); out_ready = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_after_valid got=%0h exp=0", out_valid); end
        n_cmp++; if (out_data !== 128'h22) begin n_err++; $display("FAIL fl_after_data got=%0h exp=22", out_data); end
        idle();
    endtask

    task automatic test_skid0;
        z_in_valid = 1; z_in_ctrl = 24'h1; z_in_data = 128'h1;
        n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready0 got=%0h exp=1", z_in_ready); end
        tick();
        n_cmp++; if (z_out_data !== 128'h1) begin n_err++; $display("FAIL s0_data1 got=%0h exp=1", z_out_data); end
        n_cmp++; if (z_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready1 got=%0h exp=0", z_in_ready); end
        z_in_ctrl = 24'h2; z_in_data = 128'h2;
        tick();
        n_cmp++; if (z_out_data !== 128'h1) begin n_err++; $display("FAIL s0_hold got=%0h exp=1", z_out_data); end
        n_cmp++; if (z_occupancy !== 2'd1) begin n_err++; $display("FAIL s0_occ got=%0d exp=1", z_occupancy); end
        n_cmp++; if (z_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready2 got=%0h exp=0", z_in_ready); end
        z_out_ready = 1;
        tick();
        n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL s0_drain got=%0h exp=0", z_out_valid); end
        n_cmp++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready3 got=%0h exp=1", z_in_ready); end
        tick();
        n_cmp++; if (z_out_data !== 128'h2) begin n_err++; $display("FAIL s0_data2 got=%0h exp=2", z_out_data); end
        n_cmp++; if (z_out_ctrl !== 24'h2) begin n_err++; $display("FAIL s0_ctrl2 got=%0h exp=2", z_out_ctrl); end
        n_cmp++; if (z_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready4 got=%0h exp=0", z_in_ready); end
        z_in_valid = 0;
        tick();
        n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL s0_end got=%0h exp=0", z_out_valid); end
        n_cmp++; if (z_occupancy !== 2'd0) begin n_err++; $display("FAIL s0_end_occ got=%0d exp=0", z_occupancy); end
        idle();
    endtask

    task automatic test_random;
        bit acc, rel;
        ent_t e;
        reset = 1; idle(); tick(); reset = 0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 1) != 0;
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 31) == 0;
            in_ctrl = 24'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            n_cmp++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready@%0d got=%0h exp=%0h", c, in_ready, q.size() < 2); end
            n_cmp++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d got=%0h exp=%0h", c, out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                n_cmp++; if (out_data !== q[0].d) begin n_err++; $display("FAIL rnd_data@%0d got=%0h exp=%0h", c, out_data, q[0].d); end
                n_cmp++; if (out_ctrl !== q[0].c) begin n_err++; $display("FAIL rnd_ctrl@%0d got=%0h exp=%0h", c, out_ctrl, q[0].c); end
            end else begin
                n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL rnd_ctrl0@%0d got=%0h exp=0", c, out_ctrl); end
            end
            acc = in_valid && q.size() < 2;
            rel = q.size() > 0 && out_ready && !stall;
            e.c = in_ctrl; e.d = in_data;
            tick();
            if (flush) q.delete();
            else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            n_cmp++; if (occupancy !== 2'(q.size())) begin n_err++; $display("FAIL rnd_occ@%0d got=%0d exp=%0d", c, occupancy, q.size()); end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_reset_mid_skid();
        test_stream();
        test_skid();
        test_flush();
        test_skid0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
